instruction_fetch_queue: RTL and testbench

Parametrised fetch stage with a decoupling instruction queue between the I-cache port and decode. It prefetches sequential words into a DEPTH-entry FIFO of {pc, instruction} pairs, so decode stalls and cache misses no longer stall each other cycle-for-cycle. It handles control-flow redirects by flushing the queue and discarding any in-flight cache response. Sits between the I-cache and ID; replaces the single IF/ID register.

---
 rtl/instruction_fetch_queue_if.sv | 29 ++
 rtl/instruction_fetch_queue.sv | 75 +++++++
 tb/tb_instruction_fetch_queue.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_if.sv
// instruction_fetch_queue_if: bundles the redirect, decode, I-cache and occupancy signals of the fetch queue
// Ports (master = fetch queue, slave = surrounding pipeline/cache):
//   redirect, redirect_pc            taken branch/jump and its target
//   id_ready, id_valid, id_pc, id_instr  decode handshake on the queue head
//   inst_read, inst_addr, inst_resp, inst_rdata  I-cache request/response
//   queue_count                      current queue occupancy
interface instruction_fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     redirect;
  logic [31:0]              redirect_pc;
  logic                     id_ready;
  logic                     id_valid;
  logic [31:0]              id_pc;
  logic [31:0]              id_instr;
  logic                     inst_read;
  logic [31:0]              inst_addr;
  logic                     inst_resp;
  logic [31:0]              inst_rdata;
  logic [$clog2(DEPTH):0]   queue_count;
  modport master (
    input  redirect, redirect_pc, id_ready, inst_resp, inst_rdata,
    output id_valid, id_pc, id_instr, inst_read, inst_addr, queue_count
  );
  modport slave (
    output redirect, redirect_pc, id_ready, inst_resp, inst_rdata,
    input  id_valid, id_pc, id_instr, inst_read, inst_addr, queue_count
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: prefetching fetch stage with a DEPTH-entry {pc, instr} queue between I-cache and decode
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  instruction_fetch_queue_if.master (redirect, decode handshake, I-cache port, queue_count)
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input logic clk,
  input logic rst,
  instruction_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {FETCH, DRAIN} state_e;
  state_e          state_q, state_d;
  logic [31:0]     pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic            req_q, req_d;
  logic            valid, hold, push, pop;
  assign valid = cnt_q != '0;
  // request stays outstanding into the next cycle
  assign hold  = req_q && !bus.inst_resp;
  assign push  = state_q == FETCH && req_q && bus.inst_resp && !bus.redirect;
  assign pop   = valid && bus.id_ready && !bus.redirect;
  assign bus.id_valid    = valid;
  assign bus.id_pc       = pc_q[head_q];
  assign bus.id_instr    = valid ? instr_q[head_q] : NOP_WORD;
  assign bus.inst_read   = req_q;
  assign bus.inst_addr   = addr_q;
  assign bus.queue_count = cnt_q;
  always_comb begin
    // DRAIN always has a request pending, so hold there just means "no response yet"
    state_d    = state_q == FETCH ? (bus.redirect && hold ? DRAIN : FETCH) : (hold ? DRAIN : FETCH);
    head_d     = bus.redirect ? '0 : head_q + AW'(pop);
    tail_d     = bus.redirect ? '0 : tail_q + AW'(push);
    cnt_d      = bus.redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    fetch_pc_d = bus.redirect ? {bus.redirect_pc[31:2], 2'b00} : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    // a new request only needs room for its own response once the old one has retired
    req_d      = hold || cnt_d < CW'(DEPTH);
    addr_d     = hold ? addr_q : fetch_pc_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      if (push) begin
        pc_q[tail_q]    <= fetch_pc_q;
        instr_q[tail_q] <= bus.inst_rdata;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: randomized and directed checks of the fetch queue against a queue-based reference model
module tb_instruction_fetch_queue;
  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vecs = 0;
  int errs = 0;
  int lat = 1;
  int age = 0;
  logic [63:0] mq [$];
  logic [31:0] m_fpc = 32'h60;
  logic [31:0] m_addr = 32'h60;
  bit m_req = 1'b0;
  bit m_drain = 1'b0;
  instruction_fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  instruction_fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic mreset();
    mq.delete();
    m_fpc = 32'h60;
    m_addr = 32'h60;
    m_req = 1'b0;
    m_drain = 1'b0;
    age = 0;
  endtask
  task automatic zero_inputs();
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b0;
    bus.inst_resp = 1'b0;
    bus.inst_rdata = '0;
  endtask
  // rs: 0 = cache answers after lat cycles, 1 = answer now, 2 = hold off, 3 = pulse inst_resp regardless
  task automatic cycle(input bit rd, input logic [31:0] rpc, input bit rdy, input int rs,
                       input logic [31:0] data, output bit got);
    bit resp;
    age = bus.inst_read ? age + 1 : 0;
    resp = rs == 1 ? bus.inst_read : rs == 2 ? 1'b0 : rs == 3 ? 1'b1 : (bus.inst_read && age > lat);
    got = resp && bus.inst_read;
    bus.redirect = rd;
    bus.redirect_pc = rpc;
    bus.id_ready = rdy;
    bus.inst_resp = resp;
    bus.inst_rdata = data;
    if (m_drain) begin
      if (rd) m_fpc = {rpc[31:2], 2'b00};
      if (resp) begin
        m_drain = 1'b0;
        m_req = 1'b0;
      end
    end else if (rd) begin
      mq.delete();
      m_fpc = {rpc[31:2], 2'b00};
      if (m_req && !resp) m_drain = 1'b1;
      else m_req = 1'b0;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_req && resp) begin
        mq.push_back({m_fpc, data});
        m_fpc += 32'd4;
        m_req = 1'b0;
      end
    end
    if (!m_req && mq.size() < DEPTH) begin
      m_req = 1'b1;
      m_addr = m_fpc;
    end
    @(posedge clk);
    #1;
    if (resp) age = 0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    zero_inputs();
    #3;
    @(negedge clk);
    rst = 1'b1;
    mreset();
  endtask
  task automatic test_reset();
    bit got;
    zero_inputs();
    rst = 1'b0;
    #12;
    vecs++; if (bus.id_valid !== 1'b0) begin errs++; $display("FAIL reset_id_valid got %h want 0", bus.id_valid); end
    vecs++; if (bus.id_pc !== 32'h0) begin errs++; $display("FAIL reset_id_pc got %h want 0", bus.id_pc); end
    vecs++; if (bus.id_instr !== NOP) begin errs++; $display("FAIL reset_id_instr got %h want %h", bus.id_instr, NOP); end
    vecs++; if (bus.inst_read !== 1'b0) begin errs++; $display("FAIL reset_inst_read got %h want 0", bus.inst_read); end
    vecs++; if (bus.inst_addr !== 32'h60) begin errs++; $display("FAIL reset_inst_addr got %h want 60", bus.inst_addr); end
    vecs++; if (bus.queue_count !== '0) begin errs++; $display("FAIL reset_count got %0d want 0", bus.queue_count); end
    @(negedge clk);
    rst = 1'b1;
    mreset();
    cycle(1'b0, '0, 1'b1, 2, '0, got);
    vecs++; if (bus.inst_read !== 1'b1 || bus.inst_addr !== 32'h60) begin errs++; $display("FAIL first_request got read=%h addr=%h want 1/60", bus.inst_read, bus.inst_addr); end
  endtask
  task automatic test_stream();
    bit got;
    logic [31:0] exp_pc;
    exp_pc = 32'h60;
    do_reset();
    lat = 1;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, '0, 1'b1, 0, 32'hA000_0000 + i, got);
      vecs++; if (bus.queue_count > CW'(1)) begin errs++; $display("FAIL stream_count got %0d want <=1", bus.queue_count); end
      if (bus.inst_read) begin
        vecs++; if (bus.inst_addr !== m_addr) begin errs++; $display("FAIL stream_addr got %h want %h", bus.inst_addr, m_addr); end
      end
      if (bus.id_valid) begin
        vecs++; if (bus.id_pc !== exp_pc) begin errs++; $display("FAIL stream_pc got %h want %h", bus.id_pc, exp_pc); end
        vecs++; if (mq.size() == 0 || bus.id_instr !== mq[0][31:0]) begin errs++; $display("FAIL stream_instr got %h", bus.id_instr); end
        exp_pc += 32'd4;
      end
    end
    vecs++; if (exp_pc < 32'h6C) begin errs++; $display("FAIL stream_progress got next pc %h want >= 6c", exp_pc); end
  endtask
  task automatic test_full();
    bit got;
    int n;
    n = 0;
    do_reset();
    lat = 1;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, '0, 1'b0, 0, $urandom, got);
      if (got) n++;
    end
    vecs++; if (n != 4) begin errs++; $display("FAIL full_accepted got %0d want 4", n); end
    vecs++; if (bus.queue_count !== CW'(4)) begin errs++; $display("FAIL full_count got %0d want 4", bus.queue_count); end
    vecs++; if (bus.inst_read !== 1'b0) begin errs++; $display("FAIL full_read got %h want 0", bus.inst_read); end
    vecs++; if (bus.id_pc !== 32'h60) begin errs++; $display("FAIL full_head got %h want 60", bus.id_pc); end
    cycle(1'b0, '0, 1'b1, 2, '0, got);
    vecs++; if (bus.queue_count !== CW'(3) || bus.id_pc !== 32'h64) begin errs++; $display("FAIL full_pop got count=%0d pc=%h want 3/64", bus.queue_count, bus.id_pc); end
    vecs++; if (bus.inst_read !== 1'b1 || bus.inst_addr !== 32'h70) begin errs++; $display("FAIL full_reissue got read=%h addr=%h want 1/70", bus.inst_read, bus.inst_addr); end
  endtask
  task automatic test_redirect_drain();
    bit got;
    bit found;
    bit drained;
    found = 1'b0;
    drained = 1'b0;
    do_reset();
    lat = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.inst_read && bus.inst_addr == 32'h68) found = 1'b1;
      else cycle(1'b0, '0, 1'b1, 0, $urandom, got);
    end
    vecs++; if (!found) begin errs++; $display("FAIL drain_setup got no request to 68 want one"); end
    lat = 3;
    cycle(1'b1, 32'h1003, 1'b1, 2, '0, got);
    vecs++; if (bus.inst_read !== 1'b1 || bus.inst_addr !== 32'h68) begin errs++; $display("FAIL drain_hold got read=%h addr=%h want 1/68", bus.inst_read, bus.inst_addr); end
    vecs++; if (bus.queue_count !== '0 || bus.id_valid !== 1'b0) begin errs++; $display("FAIL drain_empty got count=%0d valid=%h want 0/0", bus.queue_count, bus.id_valid); end
    for (int i = 0; i < 10 && !drained; i++) begin
      cycle(1'b0, '0, 1'b1, 0, 32'hDEAD_BEEF, got);
      drained = got;
      if (!got) begin
        vecs++; if (bus.inst_addr !== 32'h68 || bus.queue_count !== '0) begin errs++; $display("FAIL drain_wait got addr=%h count=%0d want 68/0", bus.inst_addr, bus.queue_count); end
      end
    end
    vecs++; if (!drained || bus.inst_read !== 1'b1 || bus.inst_addr !== 32'h1000) begin errs++; $display("FAIL drain_target got read=%h addr=%h want 1/1000", bus.inst_read, bus.inst_addr); end
    for (int i = 0; i < 10 && !bus.id_valid; i++) cycle(1'b0, '0, 1'b0, 0, 32'h1000_0001, got);
    vecs++; if (bus.id_pc !== 32'h1000 || bus.id_instr !== 32'h1000_0001) begin errs++; $display("FAIL drain_first got pc=%h instr=%h want 1000/10000001", bus.id_pc, bus.id_instr); end
  endtask
  task automatic test_redirect_same();
    bit got;
    do_reset();
    lat = 1;
    for (int i = 0; i < 20 && !(bus.id_valid && bus.inst_read); i++) cycle(1'b0, '0, 1'b1, 0, $urandom, got);
    vecs++; if (!(bus.id_valid && bus.inst_read)) begin errs++; $display("FAIL same_setup got valid=%h read=%h want 1/1", bus.id_valid, bus.inst_read); end
    cycle(1'b1, 32'h400, 1'b1, 1, 32'hBADC_0DE0, got);
    vecs++; if (!got || bus.id_valid !== 1'b0 || bus.queue_count !== '0) begin errs++; $display("FAIL same_flush got valid=%h count=%0d want 0/0", bus.id_valid, bus.queue_count); end
    vecs++; if (bus.inst_read !== 1'b1 || bus.inst_addr !== 32'h400) begin errs++; $display("FAIL same_target got read=%h addr=%h want 1/400", bus.inst_read, bus.inst_addr); end
    for (int i = 0; i < 10 && !bus.id_valid; i++) cycle(1'b0, '0, 1'b0, 0, 32'h4000_0001, got);
    vecs++; if (bus.id_pc !== 32'h400 || bus.id_instr !== 32'h4000_0001) begin errs++; $display("FAIL same_first got pc=%h instr=%h want 400/40000001", bus.id_pc, bus.id_instr); end
  endtask
  task automatic test_double_redirect();
    bit got;
    bit drained;
    drained = 1'b0;
    do_reset();
    lat = 5;
    cycle(1'b0, '0, 1'b1, 2, '0, got);
    cycle(1'b1, 32'h200, 1'b1, 2, '0, got);
    cycle(1'b1, 32'h300, 1'b1, 2, '0, got);
    vecs++; if (bus.inst_addr !== 32'h60 || bus.id_valid !== 1'b0) begin errs++; $display("FAIL dbl_hold got addr=%h valid=%h want 60/0", bus.inst_addr, bus.id_valid); end
    for (int i = 0; i < 10 && !drained; i++) begin
      cycle(1'b0, '0, 1'b1, 0, 32'h5555_5555, got);
      drained = got;
    end
    vecs++; if (!drained || bus.inst_read !== 1'b1 || bus.inst_addr !== 32'h300) begin errs++; $display("FAIL dbl_target got read=%h addr=%h want 1/300", bus.inst_read, bus.inst_addr); end
    for (int i = 0; i < 12 && !bus.id_valid; i++) cycle(1'b0, '0, 1'b0, 0, 32'h3000_0001, got);
    vecs++; if (bus.id_pc !== 32'h300 || bus.id_instr !== 32'h3000_0001) begin errs++; $display("FAIL dbl_first got pc=%h instr=%h want 300/30000001", bus.id_pc, bus.id_instr); end
  endtask
  task automatic test_async_reset();
    bit got;
    do_reset();
    lat = 1;
    for (int i = 0; i < 30 && !(bus.queue_count == CW'(3) && bus.inst_read); i++) cycle(1'b0, '0, 1'b0, 0, $urandom, got);
    vecs++; if (bus.queue_count !== CW'(3) || bus.inst_read !== 1'b1) begin errs++; $display("FAIL arst_setup got count=%0d read=%h want 3/1", bus.queue_count, bus.inst_read); end
    #2;
    rst = 1'b0;
    #1;
    vecs++; if (bus.id_valid !== 1'b0 || bus.queue_count !== '0) begin errs++; $display("FAIL arst_queue got valid=%h count=%0d want 0/0", bus.id_valid, bus.queue_count); end
    vecs++; if (bus.id_pc !== 32'h0 || bus.id_instr !== NOP) begin errs++; $display("FAIL arst_id got pc=%h instr=%h want 0/13", bus.id_pc, bus.id_instr); end
    vecs++; if (bus.inst_read !== 1'b0 || bus.inst_addr !== 32'h60) begin errs++; $display("FAIL arst_cache got read=%h addr=%h want 0/60", bus.inst_read, bus.inst_addr); end
    zero_inputs();
    @(negedge clk);
    rst = 1'b1;
    mreset();
    cycle(1'b0, '0, 1'b1, 2, '0, got);
    vecs++; if (bus.inst_read !== 1'b1 || bus.inst_addr !== 32'h60) begin errs++; $display("FAIL arst_restart got read=%h addr=%h want 1/60", bus.inst_read, bus.inst_addr); end
  endtask
  task automatic test_random();
    bit got;
    logic [31:0] exp_i;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      lat = $urandom_range(1, 4);
      cycle($urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0 ? 3 : 0, $urandom, got);
      exp_i = mq.size() != 0 ? mq[0][31:0] : NOP;
      vecs++; if (bus.queue_count !== CW'(mq.size()) || bus.id_valid !== (mq.size() != 0)) begin errs++; $display("FAIL rnd_count cyc %0d got count=%0d valid=%h want %0d", i, bus.queue_count, bus.id_valid, mq.size()); end
      vecs++; if (bus.id_instr !== exp_i) begin errs++; $display("FAIL rnd_instr cyc %0d got %h want %h", i, bus.id_instr, exp_i); end
      if (mq.size() != 0) begin
        vecs++; if (bus.id_pc !== mq[0][63:32]) begin errs++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, bus.id_pc, mq[0][63:32]); end
      end
      vecs++; if (bus.inst_read !== m_req) begin errs++; $display("FAIL rnd_read cyc %0d got %h want %h", i, bus.inst_read, m_req); end
      if (m_req) begin
        vecs++; if (bus.inst_addr !== m_addr) begin errs++; $display("FAIL rnd_addr cyc %0d got %h want %h", i, bus.inst_addr, m_addr); end
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    zero_inputs();
    test_reset();
    test_stream();
    test_full();
    test_redirect_drain();
    test_redirect_same();
    test_double_redirect();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
